// File: rtl/fifo_operand_reader.sv
// fifo_operand_reader: drains the async FIFO read side into (op_a, op_b) pairs.
// Optional odd-word flush input enabled by defining FIFO_OPERAND_FLUSH_EN.
`timescale 1ns/1ps
module fifo_operand_reader #(
  parameter int DATA_LEN      = 16,
  parameter int SKID_DEPTH    = 4,
  parameter int SKID_ADDR_LEN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_LEN-1:0]      fifo_data_out,
  input  logic                     fifo_rd_empty,
  output logic                     fifo_rd_en,
`ifdef FIFO_OPERAND_FLUSH_EN
  input  logic                     flush,
`endif
  output logic [DATA_LEN-1:0]      op_a,
  output logic [DATA_LEN-1:0]      op_b,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [SKID_ADDR_LEN:0]   words_buffered
);

  localparam int CW = SKID_ADDR_LEN + 1;

  logic [DATA_LEN-1:0]      r_skid [SKID_DEPTH];
  logic [SKID_ADDR_LEN-1:0] r_wr_ptr;
  logic [SKID_ADDR_LEN-1:0] r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic                     r_inflight;

  logic [CW:0]              w_occupied;
  logic                     w_room;
  logic                     w_slot_free;
  logic                     w_pair_ld;
  logic                     w_flush_ld;
  logic [SKID_ADDR_LEN-1:0] w_rd_ptr_p1;
  logic [CW-1:0]            w_count_nxt;

  // Words held plus the one still coming back from the FIFO.
  assign w_occupied  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_room      = w_occupied < (CW+1)'(SKID_DEPTH);
  assign fifo_rd_en  = ~fifo_rd_empty & ~reset & w_room;

  assign w_slot_free = ~op_valid | op_ready;
  assign w_pair_ld   = (r_count >= CW'(2)) & w_slot_free;
  assign w_rd_ptr_p1 = r_rd_ptr + SKID_ADDR_LEN'(1);

`ifdef FIFO_OPERAND_FLUSH_EN
  // A lone word may leave with a zero partner once nothing is in flight.
  assign w_flush_ld  = flush & (r_count == CW'(1)) & ~r_inflight
                     & w_slot_free;
`else
  assign w_flush_ld  = 1'b0;
`endif

  assign words_buffered = r_count;

  // Occupancy after this cycle's capture and pair/flush removal.
  always_comb begin
    w_count_nxt = r_count;
    if (r_inflight) w_count_nxt = w_count_nxt + CW'(1);
    if (w_pair_ld)
      w_count_nxt = w_count_nxt - CW'(2);
    else if (w_flush_ld)
      w_count_nxt = w_count_nxt - CW'(1);
  end

  // Skid bookkeeping: pointers, count and the in-flight read flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_count    <= w_count_nxt;
      if (r_inflight)
        r_wr_ptr <= r_wr_ptr + SKID_ADDR_LEN'(1);
      if (w_pair_ld)
        r_rd_ptr <= r_rd_ptr + SKID_ADDR_LEN'(2);
      else if (w_flush_ld)
        r_rd_ptr <= w_rd_ptr_p1;
    end
  end

  // Capture FIFO data only in the cycle after an accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++)
        r_skid[i] <= '0;
    end else if (r_inflight) begin
      r_skid[r_wr_ptr] <= fifo_data_out;
    end
  end

  // Operand register: load a pair, flush a lone word, or drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
    end else if (w_pair_ld) begin
      op_a     <= r_skid[r_rd_ptr];
      op_b     <= r_skid[w_rd_ptr_p1];
      op_valid <= 1'b1;
    end else if (w_flush_ld) begin
      op_a     <= r_skid[r_rd_ptr];
      op_b     <= '0;
      op_valid <= 1'b1;
    end else if (op_valid & op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_operand_reader.sv
// tb_fifo_operand_reader: FIFO model plus pair scoreboard for the reader.
// Expected pairs are formed from consecutive pushed words.
`timescale 1ns/1ps
module tb_fifo_operand_reader;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_rd_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [AW:0]   words_buffered;
`ifdef FIFO_OPERAND_FLUSH_EN
  logic          flush = 1'b0;
`endif

  fifo_operand_reader #(
    .DATA_LEN(DW), .SKID_DEPTH(DEPTH), .SKID_ADDR_LEN(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en(fifo_rd_en),
`ifdef FIFO_OPERAND_FLUSH_EN
    .flush(flush),
`endif
    .op_a(op_a),
    .op_b(op_b),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .words_buffered(words_buffered)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nwords;
    logic [15:0] base;
    int          stall;
    bit          tog;
    int          exp_pairs;
    int          exp_rden;
  } scn_t;

  logic [DW-1:0]   q_fifo[$];
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   half;
  bit              have_half;
  bit              rd_pending;
  bit              toggle_en;
  bit              tog;
  int              edge_cnt;
  int              rden_cnt, viol_empty, viol_hold, max_wb;
  int              valid_cyc, pairs_seen;
  int              first_rd_edge, first_v_edge;
  bit              prev_v, prev_r;
  logic [DW-1:0]   prev_a, prev_b;
  int              total, passed;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clr_stats();
    rden_cnt = 0; viol_empty = 0; viol_hold = 0; max_wb = 0;
    valid_cyc = 0; pairs_seen = 0;
    first_rd_edge = -1; first_v_edge = -1;
  endtask

  // Reference: every two pushed words form the next expected pair.
  task automatic push_word(input logic [DW-1:0] w);
    q_fifo.push_back(w);
    if (have_half) begin
      exp_q.push_back({half, w});
      have_half = 1'b0;
    end else begin
      half = w;
      have_half = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || q_fifo.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_drain"}, 32'(n < budget), 32'd1);
    repeat (4) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q_fifo.delete();
    exp_q.delete();
    have_half = 1'b0;
    rd_pending = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  always @(posedge clk) edge_cnt++;

  // FIFO model with one-cycle registered read data.
  always @(posedge clk) begin
    #1;
    if (rd_pending && q_fifo.size() > 0)
      fifo_data_out = q_fifo.pop_front();
    tog = ~tog;
    fifo_rd_empty = (q_fifo.size() == 0) || (toggle_en && tog);
  end

  // Monitor: handshake rules, hold stability, pair ordering.
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
      rd_pending = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        rden_cnt++;
        if (fifo_rd_empty) viol_empty++;
        if (first_rd_edge < 0) first_rd_edge = edge_cnt + 1;
      end
      rd_pending = fifo_rd_en;
      if (int'(words_buffered) > max_wb) max_wb = int'(words_buffered);
      if (op_valid) begin
        valid_cyc++;
        if (first_v_edge < 0) first_v_edge = edge_cnt;
      end
      if (prev_v && !prev_r &&
          (!op_valid || op_a !== prev_a || op_b !== prev_b))
        viol_hold++;
      if (op_valid && op_ready) begin
        pairs_seen++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL pair_extra: got %h%h, none expected", op_a, op_b);
        end else begin
          chk("pair_order", {op_a, op_b}, exp_q.pop_front());
        end
      end
      prev_v = op_valid;
      prev_r = op_ready;
      prev_a = op_a;
      prev_b = op_b;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    scn_t tbl[4];
    int   n;
    tbl[0] = '{2, 16'h0003, 0,  1'b0, 1, 2};
    tbl[1] = '{8, 16'h0001, 0,  1'b0, 4, 8};
    tbl[2] = '{8, 16'h0001, 20, 1'b0, 4, 8};
    tbl[3] = '{6, 16'h0100, 0,  1'b1, 3, 6};
    total = 0; passed = 0; edge_cnt = 0;
    tog = 1'b0; toggle_en = 1'b0; have_half = 1'b0; rd_pending = 1'b0;
    clr_stats();

    step();
    #1;
    chk("rst_valid", 32'(op_valid), 32'd0);
    chk("rst_rden", 32'(fifo_rd_en), 32'd0);
    chk("rst_wb", 32'(words_buffered), 32'd0);
    chk("rst_opa", 32'(op_a), 32'd0);
    chk("rst_opb", 32'(op_b), 32'd0);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      clr_stats();
      toggle_en = tbl[i].tog;
      op_ready = (tbl[i].stall == 0);
      for (int w = 0; w < tbl[i].nwords; w++)
        push_word(tbl[i].base + 16'(w));
      if (tbl[i].stall > 0) begin
        repeat (tbl[i].stall) step();
        chk($sformatf("s%0d_stall_rden", i), 32'(fifo_rd_en), 32'd0);
        chk($sformatf("s%0d_stall_wb", i), 32'(words_buffered), 32'd4);
        chk($sformatf("s%0d_stall_v", i), 32'(op_valid), 32'd1);
        chk($sformatf("s%0d_stall_a", i), 32'(op_a), 32'(tbl[i].base));
        chk($sformatf("s%0d_stall_b", i), 32'(op_b),
            32'(tbl[i].base + 16'd1));
        op_ready = 1'b1;
      end
      wait_drain($sformatf("s%0d", i), 300);
      chk($sformatf("s%0d_pairs", i), pairs_seen, tbl[i].exp_pairs);
      chk($sformatf("s%0d_rden", i), rden_cnt, tbl[i].exp_rden);
      chk($sformatf("s%0d_hold", i), viol_hold, 0);
      chk($sformatf("s%0d_rd_empty", i), viol_empty, 0);
      chk($sformatf("s%0d_maxwb", i), 32'(max_wb <= DEPTH), 32'd1);
      if (i == 0) begin
        // rd_en is accepted on an edge; op_valid rises 3 edges later.
        chk("s0_latency", first_v_edge - first_rd_edge, 3);
        chk("s0_valid_cycles", valid_cyc, 1);
      end
      toggle_en = 1'b0;
    end

    // Lone word waits for a partner.
    do_reset();
    clr_stats();
    op_ready = 1'b1;
    push_word(16'h00AA);
    repeat (20) step();
    chk("lone_no_valid", valid_cyc, 0);
    chk("lone_wb", 32'(words_buffered), 32'd1);
`ifdef FIFO_OPERAND_FLUSH_EN
    exp_q.push_back({half, 16'h0000});
    have_half = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_drain("flush", 50);
    chk("flush_pairs", pairs_seen, 1);
    chk("flush_wb", 32'(words_buffered), 32'd0);
`endif

    // Reset the cycle after a read while a pair is held.
    do_reset();
    clr_stats();
    op_ready = 1'b0;
    push_word(16'h0001);
    push_word(16'h0002);
    n = 0;
    while (!op_valid && n < 50) begin step(); n++; end
    chk("mid_valid_seen", 32'(op_valid), 32'd1);
    push_word(16'h0003);
    n = 0;
    while (!fifo_rd_en && n < 50) begin step(); n++; end
    chk("mid_rden_seen", 32'(fifo_rd_en), 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(op_valid), 32'd0);
    chk("mid_rst_wb", 32'(words_buffered), 32'd0);
    q_fifo.delete();
    exp_q.delete();
    have_half = 1'b0;
    rd_pending = 1'b0;
    step();
    reset = 1'b0;
    step();
    clr_stats();
    op_ready = 1'b1;
    push_word(16'h0010);
    push_word(16'h0011);
    wait_drain("post_rst", 50);
    chk("post_rst_pairs", pairs_seen, 1);

    // Random words, random ready and empty gaps.
    do_reset();
    clr_stats();
    for (int k = 0; k < 40; k++) begin
      push_word(16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        op_ready = ($urandom_range(0, 3) != 0);
        toggle_en = $urandom_range(0, 1) == 1;
        step();
      end
    end
    repeat (30) begin
      op_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    toggle_en = 1'b0;
    op_ready = 1'b1;
    wait_drain("rand", 400);
    chk("rand_pairs", pairs_seen, 20);
    chk("rand_rden", rden_cnt, 40);
    chk("rand_hold", viol_hold, 0);
    chk("rand_rd_empty", viol_empty, 0);
    chk("rand_maxwb", 32'(max_wb <= DEPTH), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
